// File: rtl/lcd1602_pkg.sv
// Shared commands, controller state type and glyph ROM for the LCD1602 refresh path.
// Build option LCD1602_CGRAM_EN adds a CGRAM glyph preload stage after init.
package lcd1602_pkg;

  localparam logic [7:0] CMD_FUNC_8BIT = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_LINE1     = 8'h80;
  localparam logic [7:0] CMD_LINE2     = 8'hC0;
  localparam logic [7:0] CMD_CGRAM0    = 8'h40;

  typedef enum logic [3:0] {
    StPwrup,
    StInit,
`ifdef LCD1602_CGRAM_EN
    StCgload,
`endif
    StIdle,
    StL1Addr,
    StL1Data,
    StL2Addr,
    StL2Data,
    StDone
  } ctrl_state_e;

`ifdef LCD1602_CGRAM_EN
  // Glyphs for codes 0x00..0x02 (heart, smile, up arrow), row 0 first; only 5 LSBs are pixels.
  localparam logic [0:23][7:0] GLYPH_ROM = {
    8'h00, 8'h0A, 8'h1F, 8'h1F, 8'h0E, 8'h04, 8'h00, 8'h00,
    8'h00, 8'h0A, 8'h00, 8'h00, 8'h11, 8'h0E, 8'h00, 8'h00,
    8'h04, 8'h0E, 8'h15, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00
  };
`endif

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd1602_write_phy.sv
// Single-byte HD44780 write: setup, EN pulse, hold, then a fixed settle wait
// (long wait after a clear), followed by a one-cycle done pulse.
module lcd1602_write_phy
  import lcd1602_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned EN_CYC    = 25,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned CMD_CYC   = 2500,
  parameter int unsigned CLR_CYC   = 100000
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       long_wait_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       lcd_rs_o,
  output logic       lcd_en_o,
  output logic [7:0] lcd_d_o
);

  localparam int unsigned CntW = $clog2(max2(max2(CMD_CYC, CLR_CYC),
                                             max2(EN_CYC, max2(SETUP_CYC, HOLD_CYC))) + 1);
  localparam logic [CntW-1:0] SetupLast = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] EnLast    = CntW'(EN_CYC - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] CmdLast   = CntW'(CMD_CYC - 1);
  localparam logic [CntW-1:0] ClrLast   = CntW'(CLR_CYC - 1);

  typedef enum logic [2:0] {PhyIdle, PhySetup, PhyEn, PhyHold, PhyWait} phy_state_e;

  phy_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rs_q, rs_d, en_q, en_d, long_q, long_d, done_q, done_d;
  logic [7:0]      d_q, d_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    d_d     = d_q;
    en_d    = en_q;
    long_d  = long_q;
    done_d  = 1'b0;
    unique case (state_q)
      PhyIdle: if (start_i) begin
        state_d = PhySetup;
        cnt_d   = '0;
        rs_d    = rs_i;
        d_d     = data_i;
        long_d  = long_wait_i;
      end
      PhySetup: if (cnt_q == SetupLast) begin
        state_d = PhyEn;
        cnt_d   = '0;
        en_d    = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      PhyEn: if (cnt_q == EnLast) begin
        state_d = PhyHold;
        cnt_d   = '0;
        en_d    = 1'b0;
      end else cnt_d = cnt_q + 1'b1;
      PhyHold: if (cnt_q == HoldLast) begin
        state_d = PhyWait;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      PhyWait: if (cnt_q == (long_q ? ClrLast : CmdLast)) begin
        state_d = PhyIdle;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      default: begin
        state_d = PhyIdle;
        en_d    = 1'b0;
      end
    endcase
  end

  // Async reset drops EN at once, aborting any write in flight.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= PhyIdle;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      d_q     <= 8'h00;
      en_q    <= 1'b0;
      long_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      d_q     <= d_d;
      en_q    <= en_d;
      long_q  <= long_d;
      done_q  <= done_d;
    end
  end

  assign busy_o   = (state_q != PhyIdle);
  assign done_o   = done_q;
  assign lcd_rs_o = rs_q;
  assign lcd_en_o = en_q;
  assign lcd_d_o  = d_q;

endmodule

// File: rtl/lcd1602_refresh_ctrl.sv
// LCD1602 power-up/init sequencer and two-line refresher; byte timing lives in the phy.
// Define LCD1602_CGRAM_EN to preload three custom glyphs before the first idle.
module lcd1602_refresh_ctrl
  import lcd1602_pkg::*;
#(
  parameter int unsigned PWRUP_CYC = 1000000,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned EN_CYC    = 25,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned CMD_CYC   = 2500,
  parameter int unsigned CLR_CYC   = 100000
) (
  input  logic         CLOCK,
  input  logic         RST_n,
  input  logic [127:0] line_rom1,
  input  logic [127:0] line_rom2,
  input  logic         iCall,
  output logic         oDone,
  output logic         LCD1602_RS,
  output logic         LCD1602_RW,
  output logic         LCD1602_EN,
  output logic [7:0]   LCD1602_D
);

  localparam int unsigned CntW = $clog2(max2(PWRUP_CYC, CLR_CYC) + 1);
  localparam logic [CntW-1:0] PwrupLast = CntW'(PWRUP_CYC - 1);

  ctrl_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      idx_q, idx_d;
  logic [127:0]    snap1_q, snap1_d, snap2_q, snap2_d;
  logic            done_q, done_d;
  logic            start, wr_rs, long_wait, phy_busy, phy_done;
  logic [7:0]      wr_data;
`ifdef LCD1602_CGRAM_EN
  logic [4:0]      glyph_idx;
  assign glyph_idx = idx_q - 5'd1;
`endif

  // Bytes are issued whenever the phy is idle (including its done cycle); states that
  // end a sequence wait for the final done before moving on.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap1_d = snap1_q;
    snap2_d = snap2_q;
    done_d  = 1'b0;
    start   = 1'b0;
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    unique case (state_q)
      StPwrup: if (cnt_q == PwrupLast) begin
        state_d = StInit;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      StInit: begin
        case (idx_q[1:0])
          2'd0:    wr_data = CMD_FUNC_8BIT;
          2'd1:    wr_data = CMD_DISP_ON;
          2'd2:    wr_data = CMD_ENTRY_INC;
          default: wr_data = CMD_CLEAR;
        endcase
        if (!phy_busy && idx_q < 5'd4) begin
          start = 1'b1;
          idx_d = idx_q + 5'd1;
        end else if (phy_done && idx_q == 5'd4) begin
          idx_d = '0;
`ifdef LCD1602_CGRAM_EN
          state_d = StCgload;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef LCD1602_CGRAM_EN
      StCgload: begin
        if (idx_q == 5'd0) begin
          wr_data = CMD_CGRAM0;
        end else if (idx_q == 5'd25) begin
          wr_data = CMD_LINE1;
        end else begin
          wr_rs   = 1'b1;
          wr_data = GLYPH_ROM[glyph_idx];
        end
        if (!phy_busy && idx_q < 5'd26) begin
          start = 1'b1;
          idx_d = idx_q + 5'd1;
        end else if (phy_done && idx_q == 5'd26) begin
          idx_d   = '0;
          state_d = StIdle;
        end
      end
`endif
      StIdle: if (iCall) begin
        snap1_d = line_rom1;
        snap2_d = line_rom2;
        state_d = StL1Addr;
      end
      StL1Addr: begin
        wr_data = CMD_LINE1;
        if (!phy_busy) begin
          start   = 1'b1;
          idx_d   = '0;
          state_d = StL1Data;
        end
      end
      StL1Data: begin
        wr_rs   = 1'b1;
        wr_data = snap1_q[{~idx_q[3:0], 3'b000} +: 8];
        if (!phy_busy) begin
          start = 1'b1;
          if (idx_q[3:0] == 4'd15) begin
            idx_d   = '0;
            state_d = StL2Addr;
          end else idx_d = idx_q + 5'd1;
        end
      end
      StL2Addr: begin
        wr_data = CMD_LINE2;
        if (!phy_busy) begin
          start   = 1'b1;
          idx_d   = '0;
          state_d = StL2Data;
        end
      end
      StL2Data: begin
        wr_rs   = 1'b1;
        wr_data = snap2_q[{~idx_q[3:0], 3'b000} +: 8];
        if (!phy_busy && idx_q < 5'd16) begin
          start = 1'b1;
          idx_d = idx_q + 5'd1;
        end else if (phy_done && idx_q == 5'd16) begin
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StPwrup;
    endcase
  end

  assign long_wait = !wr_rs && (wr_data == CMD_CLEAR);

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= StPwrup;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap1_q <= '0;
      snap2_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap1_q <= snap1_d;
      snap2_q <= snap2_d;
      done_q  <= done_d;
    end
  end

  lcd1602_write_phy #(
    .SETUP_CYC(SETUP_CYC),
    .EN_CYC   (EN_CYC),
    .HOLD_CYC (HOLD_CYC),
    .CMD_CYC  (CMD_CYC),
    .CLR_CYC  (CLR_CYC)
  ) u_phy (
    .CLOCK      (CLOCK),
    .RST_n      (RST_n),
    .start_i    (start),
    .rs_i       (wr_rs),
    .data_i     (wr_data),
    .long_wait_i(long_wait),
    .busy_o     (phy_busy),
    .done_o     (phy_done),
    .lcd_rs_o   (LCD1602_RS),
    .lcd_en_o   (LCD1602_EN),
    .lcd_d_o    (LCD1602_D)
  );

  assign oDone      = done_q;
  assign LCD1602_RW = 1'b0;

endmodule

// File: tb/tb_lcd1602_refresh_ctrl.sv
// Directed bench for lcd1602_refresh_ctrl with short timing; logs every EN rise and oDone pulse.
// Expects the CGRAM preload bytes only when LCD1602_CGRAM_EN is defined.
module tb_lcd1602_refresh_ctrl;

  localparam int Pwrup = 10, Setup = 1, En = 2, Hold = 1, Cmd = 4, Clr = 8;
  localparam int WrCyc = Setup + En + Hold + Cmd + 1;  // back-to-back EN-rise spacing

  logic         CLOCK = 1'b0;
  logic         RST_n = 1'b0;
  logic [127:0] line_rom1, line_rom2;
  logic         iCall = 1'b0;
  logic         oDone, LCD1602_RS, LCD1602_RW, LCD1602_EN;
  logic [7:0]   LCD1602_D;

  int         n_cmp = 0, n_err = 0, cyc = 0;
  logic       en_prev = 1'b0;
  logic [7:0] wr_d[$];
  logic       wr_rs[$];
  int         wr_cyc[$];
  int         done_cyc[$];

`ifdef LCD1602_CGRAM_EN
  localparam int Off = 30;
  logic [7:0] glyph_exp [24] = '{
    8'h00, 8'h0A, 8'h1F, 8'h1F, 8'h0E, 8'h04, 8'h00, 8'h00,
    8'h00, 8'h0A, 8'h00, 8'h00, 8'h11, 8'h0E, 8'h00, 8'h00,
    8'h04, 8'h0E, 8'h15, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00};
`else
  localparam int Off = 4;
`endif

  lcd1602_refresh_ctrl #(
    .PWRUP_CYC(Pwrup), .SETUP_CYC(Setup), .EN_CYC(En),
    .HOLD_CYC (Hold),  .CMD_CYC  (Cmd),   .CLR_CYC(Clr)
  ) dut (
    .CLOCK     (CLOCK),
    .RST_n     (RST_n),
    .line_rom1 (line_rom1),
    .line_rom2 (line_rom2),
    .iCall     (iCall),
    .oDone     (oDone),
    .LCD1602_RS(LCD1602_RS),
    .LCD1602_RW(LCD1602_RW),
    .LCD1602_EN(LCD1602_EN),
    .LCD1602_D (LCD1602_D)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  always @(negedge CLOCK) begin
    if (LCD1602_EN === 1'b1 && en_prev !== 1'b1) begin
      wr_d.push_back(LCD1602_D);
      wr_rs.push_back(LCD1602_RS);
      wr_cyc.push_back(cyc);
    end
    if (oDone === 1'b1) done_cyc.push_back(cyc);
    en_prev = LCD1602_EN;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_wr(input int n, input int budget);
    int b = budget;
    while (wr_d.size() < n && b > 0) begin
      @(negedge CLOCK); #1;
      b--;
    end
    chk($sformatf("reach %0d writes", n), 32'(wr_d.size() >= n), 1);
  endtask

  task automatic wait_done(input int n, input int budget);
    int b = budget;
    while (done_cyc.size() < n && b > 0) begin
      @(negedge CLOCK); #1;
      b--;
    end
    chk($sformatf("reach %0d dones", n), 32'(done_cyc.size() >= n), 1);
  endtask

  logic [127:0] exp_l1, exp_l2;
  int base, n0, n1, n2;

  initial begin
    exp_l1    = "OpenFPGAOpenFPGA";
    exp_l2    = {"    ", 8'h00, 8'h01, 8'h02, "happy", 8'h00, "   "};
    line_rom1 = exp_l1;
    line_rom2 = exp_l2;
    iCall     = 1'b1;  // held through init; ignored until IDLE
    repeat (3) @(negedge CLOCK);
    #1;
    chk("reset RS", LCD1602_RS, 0);
    chk("reset RW", LCD1602_RW, 0);
    chk("reset EN", LCD1602_EN, 0);
    chk("reset D", LCD1602_D, 0);
    chk("reset oDone", oDone, 0);

    @(negedge CLOCK);
    RST_n = 1'b1;
    base  = cyc;
    wait_wr(Off + 1, 1000);
    line_rom1 = {16{"X"}};  // snapshot already taken; must not tear line 1
    iCall     = 1'b0;

    chk("first EN rise cycle", wr_cyc[0] - base, Pwrup + Setup + 1);
    chk("init byte 0", wr_d[0], 8'h38);
    chk("init byte 1", wr_d[1], 8'h0C);
    chk("init byte 2", wr_d[2], 8'h06);
    chk("init byte 3", wr_d[3], 8'h01);
    for (int i = 0; i < 4; i++) chk($sformatf("init rs %0d", i), wr_rs[i], 0);
    chk("init gap 0", wr_cyc[1] - wr_cyc[0], WrCyc);
    chk("init gap 1", wr_cyc[2] - wr_cyc[1], WrCyc);
`ifdef LCD1602_CGRAM_EN
    // clear wait adds Clr-Cmd, plus one cycle for the INIT->CGLOAD step
    chk("gap after clear", wr_cyc[4] - wr_cyc[3], WrCyc + (Clr - Cmd) + 1);
    chk("cgram addr", wr_d[4], 8'h40);
    chk("cgram addr rs", wr_rs[4], 0);
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("glyph %0d", i), wr_d[5 + i], glyph_exp[i]);
      chk($sformatf("glyph rs %0d", i), wr_rs[5 + i], 1);
    end
    chk("cgram exit cmd", wr_d[29], 8'h80);
`else
    // clear wait adds Clr-Cmd, plus IDLE and L1ADDR decision cycles
    chk("gap after clear", wr_cyc[4] - wr_cyc[3], WrCyc + (Clr - Cmd) + 2);
`endif

    wait_wr(Off + 34, 34 * WrCyc + 50);
    chk("line1 cmd", wr_d[Off], 8'h80);
    chk("line1 cmd rs", wr_rs[Off], 0);
    chk("line2 cmd", wr_d[Off + 17], 8'hC0);
    chk("line2 cmd rs", wr_rs[Off + 17], 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("l1 char %0d", k), wr_d[Off + 1 + k], exp_l1[127 - 8 * k -: 8]);
      chk($sformatf("l1 rs %0d", k), wr_rs[Off + 1 + k], 1);
      chk($sformatf("l2 char %0d", k), wr_d[Off + 18 + k], exp_l2[127 - 8 * k -: 8]);
      chk($sformatf("l2 rs %0d", k), wr_rs[Off + 18 + k], 1);
    end
    wait_done(1, 100);
    chk("done after last write", done_cyc[0] - wr_cyc[Off + 33], WrCyc - 1);
    repeat (40) @(negedge CLOCK);
    #1;
    chk("single oDone", done_cyc.size(), 1);
    chk("no extra writes", wr_d.size(), Off + 34);

    // Three back-to-back refreshes with iCall held high.
    n0    = wr_d.size();
    iCall = 1'b1;
    wait_done(4, 3 * 34 * WrCyc + 200);
    iCall = 1'b0;
    chk("refresh interval 1", done_cyc[2] - done_cyc[1], 34 * WrCyc + 3);
    chk("refresh interval 2", done_cyc[3] - done_cyc[2], 34 * WrCyc + 3);
    chk("new snapshot l1", wr_d[n0 + 1], 8'h58);
    chk("new snapshot l2 char 4", wr_d[n0 + 22], 8'h00);
    chk("gap between refreshes", wr_cyc[n0 + 34] - wr_cyc[n0 + 33], WrCyc + 3);
    repeat (40) @(negedge CLOCK);
    #1;
    chk("three refresh writes", wr_d.size(), n0 + 102);
    chk("four oDone total", done_cyc.size(), 4);

    // Reset while EN is high in the middle of a refresh.
    n1    = wr_d.size();
    iCall = 1'b1;
    wait_wr(n1 + 3, 200);
    iCall = 1'b0;
    chk("EN high before reset", LCD1602_EN, 1);
    RST_n = 1'b0;
    #1;
    chk("abort EN", LCD1602_EN, 0);
    chk("abort D", LCD1602_D, 0);
    chk("abort RS", LCD1602_RS, 0);
    repeat (3) @(negedge CLOCK);
    RST_n = 1'b1;
    base  = cyc;
    n2    = wr_d.size();
    wait_wr(n2 + 1, 100);
    chk("restart byte", wr_d[n2], 8'h38);
    chk("restart cycle", wr_cyc[n2] - base, Pwrup + Setup + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
